// File: rtl/matmul_ctrl_pkg.sv
// Shared protocol constants and sequencer state encoding for the UART matrix-multiply controller.
package matmul_ctrl_pkg;

    localparam logic [7:0] CMD_MATRIX_MULT = 8'h01;
    localparam logic [7:0] RSP_ACK         = 8'hAA;
    localparam logic [7:0] RSP_NACK        = 8'h55;

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        CHECK,
        ACK,
        NACK,
        LOAD,
        START,
        WAIT_DONE,
        RD,
        SEND
    } state_t;

endpackage

// File: rtl/uart_matmul_ctrl_asm.sv
// Collects four bytes MSB-first into a 32-bit word; word_valid pulses the cycle after the 4th byte.
module fp_byte_assembler
    import matmul_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;

    always_comb begin
        cnt_d   = cnt_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (clear) begin
            cnt_d = 2'd0;
        end else if (byte_valid) begin
            word_d  = {word_q[23:0], byte_in};
            cnt_d   = cnt_q + 2'd1;
            valid_d = (cnt_q == 2'd3);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_valid = valid_q;
    assign word       = word_q;

endmodule

// File: rtl/uart_matmul_ctrl.sv
// Host-protocol sequencer: header check, A/H operand load, engine start, result streaming.
// Optional inter-byte timeout on HDR/LOAD is built when RX_TIMEOUT_EN is defined.
module uart_matmul_ctrl
    import matmul_ctrl_pkg::*;
#(
    parameter int MAX_DIM        = 8,
    parameter int ADDR_W         = $clog2(MAX_DIM * MAX_DIM),
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    input  logic              tx_done,
    output logic              send_data,
    output logic [7:0]        tx_data,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [7:0]        dim_m,
    output logic [7:0]        dim_k,
    output logic [7:0]        dim_n,
    output logic              start,
    input  logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              busy,
    output logic              err
);

    localparam logic [7:0] MAX_DIM_B = 8'(MAX_DIM);

    state_t              state_q, state_d;
    logic                send_q, send_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [7:0]          dim_m_q, dim_m_d, dim_k_q, dim_k_d, dim_n_q, dim_n_d;
    logic                sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic                first_q, first_d;
    logic [31:0]         result_q, result_d;

    logic                rx_state;
    logic                word_valid;
    logic [31:0]         word;
    logic                hdr_ok;
    logic [15:0]         a_last, h_last, c_last, wr_last;
    logic                tmo_hit;

    assign rx_state = (state_q == HDR) || (state_q == LOAD);

    fp_byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_q == IDLE),
        .byte_valid (rx_done && rx_state),
        .byte_in    (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Header word layout is {a_h, a_w, h_h, h_w}; it stays in the assembler while in CHECK.
    assign hdr_ok = (word[31:24] != 8'd0) && (word[23:16] != 8'd0) &&
                    (word[15:8]  != 8'd0) && (word[7:0]   != 8'd0) &&
                    (word[31:24] <= MAX_DIM_B) && (word[23:16] <= MAX_DIM_B) &&
                    (word[15:8]  <= MAX_DIM_B) && (word[7:0]   <= MAX_DIM_B) &&
                    (word[23:16] == word[15:8]);

    assign a_last  = ({8'd0, dim_m_q} * {8'd0, dim_k_q}) - 16'd1;
    assign h_last  = ({8'd0, dim_k_q} * {8'd0, dim_n_q}) - 16'd1;
    assign c_last  = ({8'd0, dim_m_q} * {8'd0, dim_n_q}) - 16'd1;
    assign wr_last = sel_q ? h_last : a_last;

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d   = (rx_state && !rx_done) ? tmo_q + TW'(1) : '0;
        tmo_hit = rx_state && !rx_done && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        send_d     = 1'b0;
        tx_data_d  = tx_data_q;
        dim_m_d    = dim_m_q;
        dim_k_d    = dim_k_q;
        dim_n_d    = dim_n_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        rd_addr_d  = rd_addr_q;
        byte_idx_d = byte_idx_q;
        first_d    = first_q;
        result_d   = result_q;

        case (state_q)
            IDLE: begin
                sel_d     = 1'b0;
                addr_d    = '0;
                rd_addr_d = '0;
                if (rx_done) begin
                    if (rx_data == CMD_MATRIX_MULT) begin
                        state_d = HDR;
                    end else begin
                        state_d   = NACK;
                        send_d    = 1'b1;
                        tx_data_d = RSP_NACK;
                    end
                end
            end
            HDR: if (word_valid) state_d = CHECK;
            CHECK: begin
                send_d = 1'b1;
                if (hdr_ok) begin
                    state_d   = ACK;
                    tx_data_d = RSP_ACK;
                    dim_m_d   = word[31:24];
                    dim_k_d   = word[23:16];
                    dim_n_d   = word[7:0];
                end else begin
                    state_d   = NACK;
                    tx_data_d = RSP_NACK;
                end
            end
            ACK:  if (tx_done) state_d = LOAD;
            NACK: if (tx_done) state_d = IDLE;
            LOAD: begin
                if (word_valid) begin
                    if (16'(addr_q) == wr_last) begin
                        addr_d = '0;
                        if (!sel_q) sel_d = 1'b1;
                        else        state_d = START;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            START:     state_d = WAIT_DONE;
            WAIT_DONE: if (done) state_d = RD;
            RD: begin
                state_d    = SEND;
                byte_idx_d = 2'd0;
                first_d    = 1'b1;
            end
            SEND: begin
                // result_q shifts left per byte so the next byte to send always sits in [23:16].
                if (first_q) begin
                    first_d   = 1'b0;
                    result_d  = rd_data;
                    tx_data_d = rd_data[31:24];
                    send_d    = 1'b1;
                end else if (tx_done) begin
                    if (byte_idx_q == 2'd3) begin
                        if (16'(rd_addr_q) == c_last) begin
                            state_d = IDLE;
                        end else begin
                            rd_addr_d = rd_addr_q + ADDR_W'(1);
                            state_d   = RD;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        tx_data_d  = result_q[23:16];
                        result_d   = {result_q[23:0], 8'h00};
                        send_d     = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (tmo_hit) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            send_q     <= 1'b0;
            tx_data_q  <= 8'd0;
            dim_m_q    <= 8'd0;
            dim_k_q    <= 8'd0;
            dim_n_q    <= 8'd0;
            sel_q      <= 1'b0;
            addr_q     <= '0;
            rd_addr_q  <= '0;
            byte_idx_q <= 2'd0;
            first_q    <= 1'b0;
            result_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            send_q     <= send_d;
            tx_data_q  <= tx_data_d;
            dim_m_q    <= dim_m_d;
            dim_k_q    <= dim_k_d;
            dim_n_q    <= dim_n_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            rd_addr_q  <= rd_addr_d;
            byte_idx_q <= byte_idx_d;
            first_q    <= first_d;
            result_q   <= result_d;
        end
    end

    assign send_data = send_q;
    assign tx_data   = tx_data_q;
    assign wr_en     = (state_q == LOAD) && word_valid;
    assign wr_sel    = sel_q;
    assign wr_addr   = addr_q;
    assign wr_data   = word;
    assign dim_m     = dim_m_q;
    assign dim_k     = dim_k_q;
    assign dim_n     = dim_n_q;
    assign start     = (state_q == START);
    assign rd_en     = (state_q == RD);
    assign rd_addr   = rd_addr_q;
    assign busy      = (state_q != IDLE);
    assign err       = ((state_q == NACK) && tx_done) || tmo_hit;

endmodule

// File: tb/tb_uart_matmul_ctrl.sv
// Directed bench for uart_matmul_ctrl with a UART/engine model; RX_TIMEOUT_EN adds a stall test.
module tb_uart_matmul_ctrl;
    import matmul_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        tx_done = 1'b0;
    logic        done = 1'b0;
    logic [31:0] rd_data = 32'd0;

    logic        send_data, wr_en, wr_sel, start, rd_en, busy, err;
    logic [7:0]  tx_data, dim_m, dim_k, dim_n;
    logic [5:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  host_q[$];
    logic [38:0] wr_log[$];
    int          start_cnt = 0;
    int          err_cnt = 0;
    int          tx_cnt = 0;
    int          eng_cnt = 0;
    logic [31:0] c_mem [64];

    always #5 clk = ~clk;

    uart_matmul_ctrl #(.MAX_DIM(8), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
        .tx_done(tx_done), .send_data(send_data), .tx_data(tx_data),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n), .start(start), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .err(err)
    );

    // Observe DUT outputs mid-cycle; UART and engine models react from here.
    always @(negedge clk) begin
        if (send_data) begin
            host_q.push_back(tx_data);
            tx_cnt = 3;
        end
        if (wr_en) wr_log.push_back({wr_sel, wr_addr, wr_data});
        if (start) begin
            start_cnt++;
            eng_cnt = 4;
        end
        if (err) err_cnt++;
        if (rd_en) rd_data = c_mem[rd_addr];
    end

    always begin
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        done    = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) tx_done = 1'b1;
        end
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) done = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[tb] %s ok: %h", tag, got);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_hdr(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        send_byte(CMD_MATRIX_MULT);
        send_byte(a);
        send_byte(b);
        send_byte(c);
        send_byte(d);
    endtask

    task automatic wait_host(input string tag, input int n, input int budget);
        int c = 0;
        while (host_q.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        chk({tag, "_bytes_seen"}, 64'(host_q.size() >= n), 64'd1);
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_logs();
        host_q.delete();
        wr_log.delete();
        start_cnt = 0;
        err_cnt   = 0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctl"}, {57'd0, send_data, wr_en, wr_sel, start, rd_en, busy, err}, 64'd0);
        chk({tag, "_data"}, {tx_data, wr_data, wr_addr, rd_addr}, 64'd0);
        chk({tag, "_dims"}, {dim_m, dim_k, dim_n}, 64'd0);
    endtask

    task automatic run_2x2(input string tag);
        logic [31:0] a_h [8];
        logic [31:0] c_exp [4];
        a_h   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        c_exp = '{32'h41980000, 32'h41B00000, 32'h422C0000, 32'h42480000};
        clear_logs();
        for (int i = 0; i < 4; i++) c_mem[i] = c_exp[i];
        send_hdr(8'd2, 8'd2, 8'd2, 8'd2);
        wait_host({tag, "_ack"}, 1, 200);
        chk({tag, "_ack"}, 64'(host_q[0]), 64'(RSP_ACK));
        settle();
        chk({tag, "_dims"}, {dim_m, dim_k, dim_n}, {8'd2, 8'd2, 8'd2});
        for (int i = 0; i < 8; i++) send_word(a_h[i]);
        wait_host({tag, "_res"}, 17, 2000);
        chk({tag, "_nwr"}, 64'(wr_log.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_wr%0d", tag, i), 64'(wr_log[i]), {25'd0, i >= 4, 6'(i % 4), a_h[i]});
        chk({tag, "_start"}, 64'(start_cnt), 64'd1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_c%0d", tag, i),
                {32'd0, host_q[1 + 4*i], host_q[2 + 4*i], host_q[3 + 4*i], host_q[4 + 4*i]},
                {32'd0, c_exp[i]});
        settle();
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
        chk({tag, "_noerr"}, 64'(err_cnt), 64'd0);
    endtask

    task automatic run_nack(input string tag, input logic is_op, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        clear_logs();
        if (is_op) send_byte(8'h7F);
        else       send_hdr(a, b, c, d);
        wait_host(tag, 1, 200);
        chk({tag, "_rsp"}, 64'(host_q[0]), 64'(RSP_NACK));
        settle();
        chk({tag, "_err"}, 64'(err_cnt), 64'd1);
        chk({tag, "_nowr_idle"}, {32'(wr_log.size()), 31'd0, busy}, 64'd0);
    endtask

    initial begin
        int bad;
        logic [31:0] w;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        run_2x2("t1");

        run_nack("mismatch", 1'b0, 8'd2, 8'd3, 8'd2, 8'd2);
        run_nack("opcode", 1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
        run_nack("zerodim", 1'b0, 8'd0, 8'd2, 8'd2, 8'd2);
        run_nack("toobig", 1'b0, 8'd9, 8'd8, 8'd8, 8'd8);

        clear_logs();
        for (int i = 0; i < 64; i++) c_mem[i] = {8'(i), 8'hA5, 8'(255 - i), 8'h3C};
        send_hdr(8'd8, 8'd8, 8'd8, 8'd8);
        wait_host("m8_ack", 1, 200);
        chk("m8_ack", 64'(host_q[0]), 64'(RSP_ACK));
        settle();
        for (int i = 0; i < 128; i++) send_word(32'h10000000 + 32'(i));
        wait_host("m8_res", 257, 6000);
        chk("m8_nwr", 64'(wr_log.size()), 64'd128);
        chk("m8_lastA", 64'(wr_log[63]), {25'd0, 1'b0, 6'd63, 32'h1000003F});
        chk("m8_firstH", 64'(wr_log[64]), {25'd0, 1'b1, 6'd0, 32'h10000040});
        bad = 0;
        for (int i = 0; i < 128; i++)
            if (wr_log[i] !== {i >= 64, 6'(i % 64), 32'h10000000 + 32'(i)}) bad++;
        chk("m8_allwr_bad", 64'(bad), 64'd0);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            w = {host_q[1 + 4*i], host_q[2 + 4*i], host_q[3 + 4*i], host_q[4 + 4*i]};
            if (w !== c_mem[i]) bad++;
        end
        chk("m8_result_bad", 64'(bad), 64'd0);
        settle();
        chk("m8_idle_start", {31'd0, busy, 32'(start_cnt)}, 64'd1);

        clear_logs();
        send_hdr(8'd2, 8'd2, 8'd2, 8'd2);
        wait_host("rst_ack", 1, 200);
        settle();
        send_word(32'h3F800000);
        send_word(32'h40000000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("midrst");
        chk("midrst_wr2", 64'(wr_log.size()), 64'd2);
        @(posedge clk);
        #1 rst = 1'b0;
        settle();
        chk("midrst_notx", 64'(host_q.size()), 64'd1);
        run_2x2("t5");

`ifdef RX_TIMEOUT_EN
        clear_logs();
        send_hdr(8'd2, 8'd2, 8'd2, 8'd2);
        wait_host("tmo_ack", 1, 200);
        settle();
        send_word(32'h3F800000);
        send_byte(8'h40);
        repeat (120) @(posedge clk);
        @(negedge clk);
        chk("tmo_err", 64'(err_cnt), 64'd1);
        chk("tmo_idle_notx", {31'd0, busy, 32'(host_q.size())}, 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
